// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Holds the requester count, the IDLE/GRANT state type and the default
// forced-release limit used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  localparam int N_REQ                  = 8;
  localparam int PTR_W                  = 3;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Priority pointer after a release: one past the winner, wrapping 7 -> 0.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] winner);
    return winner + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: finds the first set request at or above ptr,
// wrapping from index 7 back to index 0. Purely combinational.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  logic [PTR_W-1:0] cand_s;

  // Walk the offsets from farthest to nearest so that the nearest set request wins.
  always_comb begin
    index  = 3'd0;
    any    = 1'b0;
    cand_s = 3'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = ptr + 3'(k);
      if (req[cand_s]) begin
        index = cand_s;
        any   = 1'b1;
      end else begin
        index = index;
        any   = any;
      end
    end
  end

  // Expand the winning index to a one-hot vector; all zero when nothing requests.
  always_comb begin
    pick = 8'h00;
    if (any) begin
      pick = 8'h01 << index;
    end else begin
      pick = 8'h00;
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a two-state IDLE/GRANT controller.
// A grant is held until gnt_done and is always followed by an idle cycle.
// Optional feature: define ARB_TIMEOUT_EN to force release after
// TIMEOUT_CYCLES grant cycles and pulse the timeout output.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state_r;
  logic [N_REQ-1:0] gnt_r;
  logic             gnt_valid_r;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_idx_r;

  logic [N_REQ-1:0] pick_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             pick_any_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_r;
  logic       timeout_r;
`else
  // The limit only matters with the timeout feature; keep it referenced.
  logic [7:0] unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = 8'(TIMEOUT_CYCLES);
`endif

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .pick  (pick_s),
    .index (pick_idx_s),
    .any   (pick_any_s)
  );

  // Arbitration FSM: grant from IDLE, hold in GRANT, release back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 8'h00;
      gnt_valid_r <= 1'b0;
      ptr_r       <= 3'd0;
      win_idx_r   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_r       <= 8'd0;
      timeout_r   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            gnt_r       <= pick_s;
            gnt_valid_r <= 1'b1;
            win_idx_r   <= pick_idx_s;
            state_r     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt_r       <= 8'd0;
`endif
          end else begin
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          if (gnt_done) begin
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            ptr_r       <= ptr_after(win_idx_r);
            state_r     <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_r + 8'd1 == TO_LIMIT) begin
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            ptr_r       <= ptr_after(win_idx_r);
            state_r     <= IDLE;
            timeout_r   <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + 8'd1;
          end
`else
          else begin
            state_r     <= GRANT;
          end
`endif
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 8'h00;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_r;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios followed by
// random traffic, checked against a behavioural round-robin model.
module tb_rr_arbiter_8;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_cycles;
  logic [7:0] exp_gnt;
  logic       exp_timeout;
  logic [7:0] prev_gnt;

  rr_arbiter_8 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_done  (gnt_done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cycles = 0;
    prev_gnt = 8'h00;
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input logic [7:0] r, input logic d);
    bit found;
    req      = r;
    gnt_done = d;
    @(posedge clk);
    #1;
    exp_timeout = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found    = 1'b1;
          m_owner  = (m_ptr + k) % 8;
          m_busy   = 1'b1;
          m_cycles = 0;
        end
      end
    end else begin
      m_cycles++;
      if (d) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 8;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_cycles >= TO) begin
        m_busy      = 1'b0;
        m_ptr       = (m_owner + 1) % 8;
        exp_timeout = 1'b1;
      end
`endif
    end
    exp_gnt = m_busy ? (8'h01 << m_owner) : 8'h00;
    check("gnt", {24'd0, gnt}, {24'd0, exp_gnt});
    check("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_busy});
    check("timeout", {31'd0, timeout}, {31'd0, exp_timeout});
    check("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    check("idle_gap", {31'd0, (prev_gnt != 8'h00 && gnt != 8'h00 && gnt != prev_gnt)}, 32'd0);
    prev_gnt = gnt;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 8'h00;
    gnt_done = 1'b0;
    model_reset();
    #12;
    check("reset_gnt", {24'd0, gnt}, 32'd0);
    check("reset_valid", {31'd0, gnt_valid}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 1'b0);

    // single requester, then ptr=1 proves the pointer advanced
    step(8'h01, 1'b0);
    check("first_grant", {24'd0, gnt}, 32'h01);
    step(8'h01, 1'b1);
    step(8'h03, 1'b0);
    check("ptr_after_0", {24'd0, gnt}, 32'h02);
    step(8'h03, 1'b1);

    // gnt_done in IDLE is ignored
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // all requesting: full rotation with an idle cycle between grants
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end

    // move ptr to 6, then wrap case
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    step(8'h41, 1'b0);
    check("wrap_first", {24'd0, gnt}, 32'h40);
    step(8'h41, 1'b1);
    step(8'h41, 1'b0);
    check("wrap_second", {24'd0, gnt}, 32'h01);
    step(8'h41, 1'b1);

    // grantee drops req without done: held (or forced release with timeout)
    step(8'h04, 1'b0);
    for (int c = 0; c < 20; c++) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // done on the same edge as expiry counts as a normal release
    step(8'h08, 1'b0);
    for (int c = 0; c < TO - 1; c++) step(8'h08, 1'b0);
    step(8'h08, 1'b1);
    step(8'h00, 1'b0);

    // reset mid-grant drops the grant asynchronously, then restarts at ptr 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    step(8'h10, 1'b0);
    check("pre_reset_grant", {24'd0, gnt}, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_gnt", {24'd0, gnt}, 32'd0);
    check("async_reset_valid", {31'd0, gnt_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h11, 1'b0);
    check("restart_ptr0", {24'd0, gnt}, 32'h01);
    step(8'h11, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic       d;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = ($urandom_range(0, 2) == 0);
      step(r, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles a grant is held before forced release (used only with ARB_TIMEOUT_EN; legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  8  request lines, bit i = requester i; level-sensitive.
REQ-005 gnt_done  input  1  current grantee releases the grant; sampled only in GRANT.
REQ-006 gnt  output  8  registered grant, exactly one bit set when gnt_valid=1, all zero otherwise; feeds the downstream 8-to-3 binary encoder.
REQ-007 gnt_valid  output  1  registered; qualifies gnt.
REQ-008 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-009 The block SHALL implement two states: IDLE and GRANT.
REQ-010 In IDLE with req != 0 at an edge, the block SHALL select the first set req bit at or above index ptr, wrapping 7->0, load gnt with that one-hot value, set gnt_valid=1, and enter GRANT; the grant is visible the cycle after the sampling edge (latency 1).
REQ-011 In IDLE with req == 0, gnt SHALL stay 0 and gnt_valid 0.
REQ-012 In GRANT, gnt SHALL remain stable regardless of req changes, including the grantee dropping req.
REQ-013 In GRANT with gnt_done=1 at an edge, the block SHALL clear gnt and gnt_valid, set ptr = (winner index + 1) mod 8, and return to IDLE.
REQ-014 Every grant SHALL be followed by at least one IDLE cycle with gnt=0; gnt SHALL never switch directly between two one-hot values.
REQ-015 gnt_done in IDLE SHALL be ignored.
REQ-016 ptr SHALL be 3 bits; winner 7 wraps ptr to 0.
REQ-017 gnt SHALL never carry more than one set bit in any cycle.

Reset
REQ-018 On rst_n=0, asynchronously: state=IDLE, gnt=8'h00, gnt_valid=0, timeout=0, ptr=0, timeout counter=0.
REQ-019 Reset asserted during GRANT SHALL drop the grant immediately with no gnt_done required; after release, arbitration restarts from ptr=0.

Configuration
REQ-020 Macro ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle; when it reaches TIMEOUT_CYCLES without gnt_done, the block SHALL release exactly as REQ-013 and pulse timeout=1 for one cycle.
REQ-021 Simultaneous gnt_done and timeout expiry SHALL be treated as normal release with timeout=0.
REQ-022 Macro undefined: no counter is built, grants are held indefinitely until gnt_done, and timeout is tied to 0; port list is unchanged.

Structure
REQ-023 Shared package arb_pkg SHALL hold N_REQ=8, the IDLE/GRANT state typedef, and the default TIMEOUT_CYCLES constant.
REQ-024 Combinational rotating-priority selection SHALL be a sub-module rr_pick (inputs req, ptr; outputs one-hot pick, 3-bit index, any).

Verification
REQ-025 Reset then req=8'h01 -> cycle after edge gnt=8'h01, gnt_valid=1; gnt_done -> gnt=0, ptr=1.
REQ-026 req=8'hFF held, gnt_done pulsed per grant -> grants 01,02,04,...,80,01 in order, with an idle cycle between each.
REQ-027 ptr=6, req=8'h41 -> gnt=8'h40; after done, gnt=8'h01 (wrap).
REQ-028 Granted requester drops req without gnt_done -> gnt held unchanged; with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4 -> release after 4 GRANT cycles, timeout pulses once.
REQ-029 rst_n asserted mid-GRANT with gnt=8'h10 -> gnt=0 asynchronously; after release with req=8'h11 -> gnt=8'h01.
REQ-030 gnt_done on the same edge as timeout expiry -> release with timeout=0; one-hot and idle-gap assertions checked in every test.
